// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared states, instruction classes, opcodes and ALU codes for mc_ctrl_fsm
package mc_ctrl_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_NOP, S_ALU_EXEC, S_ALU_IMM, S_ALU_LI,
    S_ALU_WB, S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_BR_CMP, S_BR_TAKE, S_TRAP
  } state_e;
  typedef enum logic [3:0] {
    CL_NOP, CL_BEQ, CL_BNE, CL_B, CL_RALU, CL_IMM, CL_LI, CL_LOAD, CL_STORE, CL_ILLEGAL
  } cls_e;
  localparam logic [5:0] OP_BEQ  = 6'h00;
  localparam logic [5:0] OP_BNE  = 6'h01;
  localparam logic [5:0] OP_B    = 6'h3F;
  localparam logic [5:0] OP_RALU = 6'h20;
  localparam logic [5:0] OP_IMM0 = 6'h30;
  localparam logic [5:0] OP_IMM1 = 6'h32;
  localparam logic [5:0] OP_IMM2 = 6'h33;
  localparam logic [5:0] OP_LI0  = 6'h38;
  localparam logic [5:0] OP_LI1  = 6'h39;
  localparam logic [5:0] OP_LD0  = 6'h03;
  localparam logic [5:0] OP_LD1  = 6'h0F;
  localparam logic [5:0] OP_ST0  = 6'h07;
  localparam logic [5:0] OP_ST1  = 6'h1F;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational instruction classifier
// Ports: instr_i (instruction), cls_o (instruction class), illegal_o (unknown opcode)
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
#(
  parameter int INSTR_W = 32
) (
  input  logic [INSTR_W-1:0] instr_i,
  output cls_e               cls_o,
  output logic               illegal_o
);
  logic [5:0] op;
  assign op = instr_i[INSTR_W-1 -: 6];
  always_comb begin
    cls_o = CL_ILLEGAL;
    if (instr_i == '0) cls_o = CL_NOP;
    else
      case (op)
        OP_BEQ:                    cls_o = CL_BEQ;
        OP_BNE:                    cls_o = CL_BNE;
        OP_B:                      cls_o = CL_B;
        OP_RALU:                   cls_o = CL_RALU;
        OP_IMM0, OP_IMM1, OP_IMM2: cls_o = CL_IMM;
        OP_LI0, OP_LI1:            cls_o = CL_LI;
        OP_LD0, OP_LD1:            cls_o = CL_LOAD;
        OP_ST0, OP_ST1:            cls_o = CL_STORE;
        default:                   cls_o = CL_ILLEGAL;
      endcase
  end
  assign illegal_o = cls_o == CL_ILLEGAL;
endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle Moore control unit with memory handshake, NOP padding and sticky trap
// Inputs: clock, reset_n (async active-low), instr, alu_zero, mem_ack
// Outputs: pc_sel, pc_ld_en, rf_wr_en, rf_wr_data_sel, rf_b_sel, alu_bin_sel, alu_func,
//          mem_req, mem_wr_en, instr_ld_en, trap
// CTRL_PERF_CNT_EN adds saturating counters instr_retired and wait_cycles.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int INSTR_W    = 32,
  parameter int ALU_FUNC_W = 4,
  parameter int NOP_CYCLES = 3,
  parameter int CNT_W      = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [INSTR_W-1:0]    instr,
  input  logic                  alu_zero,
  input  logic                  mem_ack,
  output logic                  pc_sel,
  output logic                  pc_ld_en,
  output logic                  rf_wr_en,
  output logic                  rf_wr_data_sel,
  output logic                  rf_b_sel,
  output logic                  alu_bin_sel,
  output logic [ALU_FUNC_W-1:0] alu_func,
  output logic                  mem_req,
  output logic                  mem_wr_en,
  output logic                  instr_ld_en,
  output logic                  trap
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      instr_retired,
  output logic [CNT_W-1:0]      wait_cycles
`endif
);
  localparam logic [3:0] NOP_LAST = 4'(NOP_CYCLES - 1);
  state_e     state_q, state_d;
  logic [3:0] nop_cnt_q, nop_cnt_d;
  cls_e       cls;
  logic       illegal;
  mc_ctrl_decode #(.INSTR_W(INSTR_W)) u_decode (
    .instr_i   (instr),
    .cls_o     (cls),
    .illegal_o (illegal)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q   <= S_IDLE;
      nop_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      nop_cnt_q <= nop_cnt_d;
    end
  always_comb begin
    state_d        = state_q;
    nop_cnt_d      = nop_cnt_q;
    pc_sel         = 1'b0;
    pc_ld_en       = 1'b0;
    rf_wr_en       = 1'b0;
    rf_wr_data_sel = 1'b0;
    rf_b_sel       = 1'b0;
    alu_bin_sel    = 1'b0;
    alu_func       = ALU_FUNC_W'(ALU_ADD);
    mem_req        = 1'b0;
    mem_wr_en      = 1'b0;
    instr_ld_en    = 1'b0;
    trap           = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        instr_ld_en = 1'b1;
        pc_ld_en    = 1'b1;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        nop_cnt_d = '0;
        if (illegal) state_d = S_TRAP;
        else
          case (cls)
            CL_NOP:             state_d = S_NOP;
            CL_RALU:            state_d = S_ALU_EXEC;
            CL_IMM:             state_d = S_ALU_IMM;
            CL_LI:              state_d = S_ALU_LI;
            CL_LOAD, CL_STORE:  state_d = S_MEM_ADDR;
            CL_BEQ, CL_BNE:     state_d = S_BR_CMP;
            CL_B:               state_d = S_BR_TAKE;
            default:            state_d = S_TRAP;
          endcase
      end
      S_NOP: begin
        state_d   = (nop_cnt_q == NOP_LAST) ? S_FETCH : S_NOP;
        nop_cnt_d = (nop_cnt_q == NOP_LAST) ? '0 : nop_cnt_q + 4'd1;
      end
      S_ALU_EXEC: begin
        alu_func = ALU_FUNC_W'(instr[3:0]);
        state_d  = S_ALU_WB;
      end
      S_ALU_IMM: begin
        alu_bin_sel = 1'b1;
        rf_b_sel    = 1'b1;
        alu_func    = ALU_FUNC_W'(instr[29:26]);
        state_d     = S_ALU_WB;
      end
      S_ALU_LI: begin
        alu_bin_sel = 1'b1;
        state_d     = S_ALU_WB;
      end
      S_ALU_WB: begin
        // instr is stable here, so the class recreates the previous cycle's ALU selects
        rf_wr_en    = 1'b1;
        alu_bin_sel = cls != CL_RALU;
        rf_b_sel    = cls == CL_IMM;
        alu_func    = cls == CL_RALU ? ALU_FUNC_W'(instr[3:0]) :
                      cls == CL_IMM  ? ALU_FUNC_W'(instr[29:26]) : ALU_FUNC_W'(ALU_ADD);
        state_d     = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_bin_sel = 1'b1;
        state_d     = cls == CL_LOAD ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req        = 1'b1;
        rf_wr_data_sel = 1'b1;
        rf_b_sel       = 1'b1;
        rf_wr_en       = mem_ack;
        state_d        = mem_ack ? S_FETCH : S_MEM_RD;
      end
      S_MEM_WR: begin
        mem_req   = 1'b1;
        mem_wr_en = 1'b1;
        rf_b_sel  = 1'b1;
        state_d   = mem_ack ? S_FETCH : S_MEM_WR;
      end
      S_BR_CMP: begin
        alu_func = ALU_FUNC_W'(ALU_SUB);
        rf_b_sel = 1'b1;
        state_d  = ((cls == CL_BEQ && alu_zero) || (cls == CL_BNE && !alu_zero)) ? S_BR_TAKE : S_FETCH;
      end
      S_BR_TAKE: begin
        pc_sel   = 1'b1;
        pc_ld_en = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP: trap = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end
`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] retired_q, wait_q;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      retired_q <= '0;
      wait_q    <= '0;
    end else begin
      if (state_d == S_FETCH && state_q != S_IDLE && !(&retired_q)) retired_q <= retired_q + 1'b1;
      if ((state_q == S_MEM_RD || state_q == S_MEM_WR) && !mem_ack && !(&wait_q)) wait_q <= wait_q + 1'b1;
    end
  assign instr_retired = retired_q;
  assign wait_cycles   = wait_q;
`endif
endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Parametrised multicycle control unit for the MIPS-style datapath: a Moore FSM that sequences fetch, decode, ALU, immediate, load/store, and branch instructions. It adds a memory request/acknowledge handshake with unbounded wait states, a configurable NOP padding length, and a sticky illegal-opcode trap. Outputs drive the PC, register-file, ALU and memory select/enable lines of the existing datapath.

## Interface
- INSTR_W, 32: instruction width; opcode is instr[INSTR_W-1:INSTR_W-6].
- ALU_FUNC_W, 4: ALU function code width.
- NOP_CYCLES, 3: idle cycles inserted after an all-zero instruction; legal range 1..15.
- CNT_W, 32: performance counter width (used only with CTRL_PERF_CNT_EN).
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- instr  in  INSTR_W  current instruction from the instruction register.
- alu_zero  in  1  ALU zero flag.
- mem_ack  in  1  data-memory acknowledge; one-cycle pulse completes the access.
- pc_sel, pc_ld_en  out  1  PC source select (1 = branch target) and PC load.
- rf_wr_en, rf_wr_data_sel, rf_b_sel  out  1  RF write, write-data select (1 = memory), B-port select.
- alu_bin_sel  out  1  ALU B source (1 = immediate).
- alu_func  out  ALU_FUNC_W  ALU operation.
- mem_req, mem_wr_en  out  1  memory request; write qualifier.
- instr_ld_en  out  1  instruction-register load.
- trap  out  1  sticky illegal-opcode flag.

## Operation
- Opcode classes (6-bit): 0x00 with instr≠0 is BEQ; 0x01 is BNE; 0x3F is B; 0x20 is R-ALU (func = instr[3:0]); 0x30/0x32/0x33 is ALU-imm (func = instr[29:26]); 0x38/0x39 is LI; 0x03/0x0F is LOAD; 0x07/0x1F is STORE; instr==0 is NOP. Any other opcode is illegal.
- States: IDLE, FETCH, DECODE, NOP, ALU_EXEC, ALU_IMM, ALU_LI, ALU_WB, MEM_ADDR, MEM_RD, MEM_WR, BR_CMP, BR_TAKE, TRAP.
- IDLE→FETCH unconditionally. In FETCH: instr_ld_en=1, pc_ld_en=1. FETCH→DECODE.
- DECODE selects the next state by class:
  - NOP→NOP, which holds for NOP_CYCLES cycles, then goes to FETCH.
  - R-ALU→ALU_EXEC. ALU-imm→ALU_IMM. LI→ALU_LI.
  - LOAD or STORE→MEM_ADDR. BEQ or BNE→BR_CMP. B→BR_TAKE.
  - Illegal→TRAP.
- ALU_EXEC: alu_bin_sel=0, alu_func=instr[3:0]. ALU_IMM: alu_bin_sel=1, rf_b_sel=1, alu_func=instr[29:26]. ALU_LI: alu_bin_sel=1, alu_func=0. All three go to ALU_WB.
- ALU_WB: rf_wr_en=1, rf_wr_data_sel=0, while holding the previous ALU selects. ALU_WB→FETCH.
- MEM_ADDR: alu_func=0, alu_bin_sel=1. It goes to MEM_RD for a load or MEM_WR for a store.
- MEM_RD: mem_req=1, rf_wr_data_sel=1, rf_b_sel=1; rf_wr_en=mem_ack.
- MEM_WR: mem_req=1, mem_wr_en=1, rf_b_sel=1.
- Both memory states hold until mem_ack=1, then go to FETCH.
- BR_CMP: alu_func=1 (sub), alu_bin_sel=0, rf_b_sel=1. It samples alu_zero and goes to BR_TAKE if (BEQ and zero) or (BNE and not zero), else to FETCH.
- BR_TAKE: pc_sel=1, pc_ld_en=1. BR_TAKE→FETCH.
- TRAP: trap=1 and all other outputs 0. It is absorbing until reset_n is asserted.
- Any output not listed for a state is 0. alu_func is 0 where unspecified.

## Timing
- All outputs are decoded combinationally from the registered state only. mem_ack drives rf_wr_en in MEM_RD.
- Reset: state=IDLE, every output 0, NOP counter 0, and perf counters 0.
- Cycles from FETCH to the next FETCH:
  - R-ALU, ALU-imm, LI: 4.
  - Load or store with mem_ack in the first request cycle: 4. Each extra wait cycle adds 1.
  - Branch not taken: 3. Branch taken: 4. B: 3.
  - NOP: 2+NOP_CYCLES.
- mem_req stays high and stable from entry to the MEM state until the ack cycle inclusive. mem_ack outside MEM_RD/MEM_WR is ignored.
- instr must be stable from DECODE until the FSM returns to FETCH. It is sampled in every state.
- Asserting reset_n mid-access drops mem_req immediately and returns the FSM to IDLE.

## Configuration
- CTRL_PERF_CNT_EN defined: adds outputs instr_retired [CNT_W] and wait_cycles [CNT_W].
  - instr_retired increments on every transition into FETCH except from IDLE.
  - wait_cycles increments on each MEM_RD/MEM_WR cycle with mem_ack=0.
  - Both counters saturate at all-ones and reset to 0.
- CTRL_PERF_CNT_EN undefined: neither port nor counter logic exists.

## Structure
- Package mc_ctrl_pkg holds:
  - the state enum;
  - the opcode localparams (OP_BEQ, OP_BNE, OP_B, OP_RALU, OP_LI0/1, OP_IMM*, OP_LD*, OP_ST*);
  - ALU_ADD=0 and ALU_SUB=1;
  - the instruction-class enum.
- Sub-module mc_ctrl_decode is combinational: instr → class, plus an illegal flag. It is instantiated once.

## Test plan
- Reset with reset_n=0 mid-MEM_WR: all outputs go 0 immediately; after release, IDLE then FETCH with pc_ld_en=1.
- instr=0x80000003 (R-ALU, func 3): alu_func=3 in ALU_EXEC; rf_wr_en=1 exactly one cycle later; the sequence takes 4 cycles.
- LOAD with op 0x03 and mem_ack delayed 3 cycles: mem_req high 4 cycles; rf_wr_en high only in the ack cycle; wait_cycles=3.
- BEQ with alu_zero=1 gives BR_TAKE (pc_sel=1, pc_ld_en=1). BNE with alu_zero=1 returns to FETCH with pc_sel=0.
- instr=0 with NOP_CYCLES=5: 5 NOP cycles, then FETCH. instr=0x08000000 (op 0x02): trap=1 held for 10 cycles, cleared only by reset_n.
- Apply 2^CNT_W+2 ALU instructions with CNT_W=4: instr_retired saturates at 15.
